// File: rtl/counter_pkg.sv
// Shared constants and a reference next-count function for the counter.
// Optional build macro: COUNTER_DOWN_MODE_EN (selects down counting).
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 3;
    localparam int unsigned DEFAULT_RESET_VALUE = 0;

`ifdef COUNTER_DOWN_MODE_EN
    localparam bit COUNT_DOWN = 1'b1;
`else
    localparam bit COUNT_DOWN = 1'b0;
`endif

    // Next count value modulo 2**width; width is 1..16.
    function automatic logic [15:0] next_count(
        input logic [15:0] value,
        input int unsigned width,
        input logic        down
    );
        int unsigned mask;
        int unsigned v;
        mask = (32'd1 << width) - 32'd1;
        v    = {16'd0, value};
        v    = down ? (v - 32'd1) : (v + 32'd1);
        return 16'(v & mask);
    endfunction

endpackage

// File: rtl/counter_tff_cell.sv
// One synchronous T flip-flop bit. Reset has priority over toggling.
module counter_tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic rst_val,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next state: invert the bit when t is high.
    always_comb begin
        q_d = q_q ^ t;
    end

    // Bit register with synchronous reset to its share of RESET_VALUE.
    // NOTE: sequential state uses non-blocking (<=) so every bit samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/up_counter_3bit_sync.sv
// Free-running synchronous binary counter built from T flip-flop cells.
// All bits change on the same clk edge: bit i toggles when every lower bit
// is 1 (up) or 0 (down). Build macro COUNTER_DOWN_MODE_EN selects down counting.
module up_counter_3bit_sync
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] q_bits;     // register outputs of the cells
    logic [WIDTH-1:0] lower_hit;  // bit i is at its "carry/borrow" value
    logic [WIDTH-1:0] t_chain;    // toggle enable per bit

    assign t_chain[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef COUNTER_DOWN_MODE_EN
        assign lower_hit[i] = ~q_bits[i];
`else
        assign lower_hit[i] = q_bits[i];
`endif
        if (i > 0) begin : g_chain
            assign t_chain[i] = t_chain[i-1] & lower_hit[i-1];
        end

        counter_tff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .t       (t_chain[i]),
            .rst_val (RST_BITS[i]),
            .q       (q_bits[i])
        );
    end

    // Q comes straight from the flops; no decode sits on the output.
    assign Q = q_bits;

    // ---------------------------------------------------------------------
    // Behavioural checks against the package reference function.
    // ---------------------------------------------------------------------
    logic [15:0] q_ext;
    logic        seen_reset_q;

    assign q_ext = 16'(Q);

    // Remembers that Q has been initialised at least once.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_reset_q <= 1'b1;
        end
    end

    a_reset_value : assert property (@(posedge clk)
        reset |=> (q_ext == 16'(RST_BITS)));

    a_next_count : assert property (@(posedge clk)
        (seen_reset_q && !reset) |=> (q_ext == next_count($past(q_ext), WIDTH, COUNT_DOWN)));

    // lower_hit[WIDTH-1] only exists for symmetry of the chain.
    logic unused_top_hit;
    assign unused_top_hit = lower_hit[WIDTH-1];

endmodule

// File: tb/tb_up_counter_3bit_sync.sv
// Self-checking bench: directed test-plan sequences followed by random
// reset/count traffic, compared against a modulo-arithmetic model.
// Two instances: default (3-bit, reset 0) and WIDTH=4, RESET_VALUE=14.
module tb_up_counter_3bit_sync;

    localparam int unsigned WA  = 3;
    localparam int unsigned RVA = 0;
    localparam int unsigned WB  = 4;
    localparam int unsigned RVB = 14;

`ifdef COUNTER_DOWN_MODE_EN
    localparam bit DOWN = 1'b1;
`else
    localparam bit DOWN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [WA-1:0] q_a;
    logic [WB-1:0] q_b;

    int unsigned vectors;
    int unsigned misses;
    int unsigned model_a;
    int unsigned model_b;

    up_counter_3bit_sync #(.WIDTH(WA), .RESET_VALUE(RVA)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .Q     (q_a)
    );

    up_counter_3bit_sync #(.WIDTH(WB), .RESET_VALUE(RVB)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .Q     (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: reset loads the reset value, otherwise step by one modulo 2**w.
    function automatic int unsigned model_next(input int unsigned cur, input int unsigned w,
                                               input int unsigned rv, input logic rst);
        int unsigned m;
        m = 1 << w;
        if (rst) return rv;
        if (DOWN) return (cur + m - 1) % m;
        return (cur + 1) % m;
    endfunction

    // Apply one clock edge with the given reset level, then compare mid-cycle.
    task automatic step(input logic rst, input string tag);
        reset = rst;
        @(posedge clk);
        model_a = model_next(model_a, WA, RVA, rst);
        model_b = model_next(model_b, WB, RVB, rst);
        @(negedge clk);
        check({tag, "_a"}, int'(q_a), model_a);
        check({tag, "_b"}, int'(q_b), model_b);
    endtask

    initial begin
        vectors = 0;
        misses  = 0;
        model_a = 0;
        model_b = 0;

        // Reset asserted from t=0, checked after the 5 ns edge.
        step(1'b1, "reset_start");

        // Full sequence through the wrap point (2**WA + 2 edges).
        for (int i = 0; i < 10; i++) begin
            step(1'b0, "count");
        end

        // Run until the small counter shows 5, then reset mid-count.
        for (int i = 0; i < 16 && model_a != 5; i++) begin
            step(1'b0, "seek5");
        end
        check("reached5", int'(q_a), 5);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "reset_held");
        end
        step(1'b0, "resume");
        step(1'b0, "resume2");

        // Random mix of resets and counting.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/up_counter_3bit_sync.md
Name: up_counter_3bit_sync

Overview:
- Free-running synchronous binary up counter. Default width is 3 bits, so Q steps 0..7 and wraps.
- One clock domain, no enable and no load.
- Used as a simple sequence and timebase source. Output Q feeds downstream logic or waveform dumps directly.

Parameters:
- WIDTH, 3, counter width in bits. Legal range is 1..16. Q wraps modulo 2**WIDTH.
- RESET_VALUE, 0, value loaded into Q on reset. Must be less than 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state changes happen on this edge.
- reset  input  1  synchronous, active-high reset.
- Q  output  WIDTH  current count, driven directly from the register with no combinational path from inputs.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, named reset. reset is sampled only on the rising edge of clk and has no asynchronous effect.
- Reset:
  - On a rising edge with reset=1, Q <= RESET_VALUE (default 3'b000).
  - Reset has priority over counting.
  - Before the first reset edge, Q is undefined and no power-on value is guaranteed.
- Count:
  - On a rising edge with reset=0, Q <= Q + 1, truncated to WIDTH bits.
  - Latency is one cycle: the first edge after reset deasserts gives Q=1 (with the default RESET_VALUE).
- Wrap-around: Q = 2**WIDTH - 1 (3'b111) followed by one count edge gives Q = 0. There is no terminal-count stall and no sticky flag.
- Reset mid-count: reset=1 at any value forces RESET_VALUE on that edge. Counting resumes from RESET_VALUE on the next edge with reset=0.
- Reset held: Q stays at RESET_VALUE for every edge while reset=1.
- Glitch-free output: Q changes only on the rising clk edge. No combinational decode is placed on Q.
- Synchronous-counter structure: every bit toggles on the same clock edge. Bit i toggles when all lower bits are 1, and bit 0 toggles every count edge. This is equivalent to the +1 rule and is the required implementation style. It must not be a ripple counter.

Optional Feature:
- Macro: COUNTER_DOWN_MODE_EN.
- Defined:
  - Down counter. On a rising edge with reset=0, Q <= Q - 1 modulo 2**WIDTH, so 0 goes to 7 for the default width.
  - Toggle rule: bit i toggles when all lower bits are 0.
  - Reset behaviour is unchanged (Q <= RESET_VALUE).
- Undefined: up counting exactly as described in Behaviour.
- Ports and parameters are identical in both builds.

Decomposition:
- Package counter_pkg:
  - localparam DEFAULT_WIDTH = 3.
  - localparam DEFAULT_RESET_VALUE = 0.
  - function next_count(value, width, down) returning the expected next value, shared by the RTL assertions and the bench model.
- Sub-module counter_tff_cell: one synchronous T flip-flop bit with inputs clk, reset, t, rst_val and output q.
  - Reset has priority over toggling.
  - The top level instantiates WIDTH cells with a generate loop and builds each cell's t input from the AND chain (up) or NOR chain (down) of the lower bits.

Test Plan:
- Reset at start: clk period 10 ns, reset=1 from t=0 to t=10 ns → Q=000 after the 5 ns edge.
- Full sequence: reset=0 from t=10 ns → Q=001 at 15 ns, 010 at 25, 011 at 35, 100 at 45, 101 at 55, 110 at 65, 111 at 75.
- Wrap: edge at 85 ns → Q=000.
- Reset mid-count: assert reset when Q=101 and hold for 3 edges → Q=000 on the first edge and on each held edge. After release, Q=001 on the next edge.
- Down build (COUNTER_DOWN_MODE_EN defined): after reset → 000, then 111, 110, …, 001, 000 on successive edges.
- Parameter check: WIDTH=4, RESET_VALUE=4'hE → after reset Q=1110, then 1111, 0000, 0001 on successive edges.
